ising_osc_solver: RTL and testbench
===================================

# ising_osc_solver

Parametrised successor to the fixed 16-spin oscillator Ising machine. Solves an N-spin Ising problem with a Kuramoto phase network: integer phases with native wrap, a triangle-wave sine approximation, second-harmonic injection locking (SHIL) that binarises phases, and decaying LFSR noise for annealing. It adds a writable coupling RAM, early exit on spin stability, and binary spin readout. It sits between the host register bank, which loads J and starts runs, and result readback.

## Interface
- N, 16: spin count (2..64)
- PW, 16: phase width, 8..16; 2^PW ≙ 2π
- JW, 8: signed coupling width
- ACCW, 32: signed accumulator width
- ITW, 16: iteration counter width
- ANNEAL, 8: iterations per noise-shift increment
- STABLE, 4: consecutive unchanged noise-free iterations needed for early exit
- clk in 1: clock
- rst in 1: asynchronous active-high reset
- start in 1: run request, sampled in IDLE only
- j_we in 1: coupling write strobe, honoured only when busy=0
- j_row, j_col in $clog2(N) each: coupling address
- j_wdata in JW: signed J[row][col]
- ks in 8: unsigned SHIL gain
- dt_shift in 4: step size; update = acc >>> dt_shift
- noise_sh0 in 5: initial noise shift (0..16; 16 = no noise)
- max_iter in ITW: iteration cap; 0 treated as 1
- busy out 1: run in progress
- done out 1: one-cycle completion pulse
- spin out N: bit i = 1 when spin i is −1
- iter_out out ITW: iterations executed in the last run

## Operation
- Reset values: busy 0, done 0, spin 0, iter_out 0, all phases 0, all J 0, LFSR 16'hACE1, state IDLE.
- States: IDLE → INIT (N cycles) → per row i: ACC (N cycles, j=0..N−1) → UPD (1 cycle); after row N−1 → ITER (1 cycle) → ACC of row 0, or FIN (1 cycle) → IDLE.
- LFSR: 16-bit, shift left, feedback lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]. Advances every INIT and UPD cycle and reloads 16'hACE1 on start.
- INIT: phi[i] ← lfsr[15:16−PW].
- tri(x), x a PW-bit phase read as signed s, with Q = 2^(PW−2): s > Q → 2^(PW−1) − s; s < −Q → −2^(PW−1) − s; else s.
- ACC, step j: acc += J[i][j] · tri(phi[j] − phi[i]). Subtraction is mod 2^PW. Term is 0 when j == i, whatever J[i][i] holds. acc clears at the start of each row.
- UPD: f = acc − ks·tri(2·phi[i]) + noise, where noise = sign-extended (lfsr >>> noise_sh), or 0 if noise_sh = 16. Then phi[i] ← phi[i] + (f >>> dt_shift), truncated to PW bits. Wrap is natural modulo. Rows are Gauss-Seidel: row i+1 sees the new phi[i].
- Spin decision: s_i = 1 iff phi[i] ∈ [Q, 3Q).
- ITER:
  - iter += 1.
  - If iter % ANNEAL == 0 and noise_sh < 16, then noise_sh += 1.
  - If noise_sh == 16, stable_cnt increments when the spin vector equals the previous ITER's vector, else it clears. While noise_sh < 16, stable_cnt stays 0.
  - Go to FIN if iter == max(max_iter, 1) or stable_cnt == STABLE.
- FIN: spin ← current spin vector, iter_out ← iter, done = 1, busy = 0.
- All arithmetic is signed, full-precision into ACCW. Overflow wraps; no saturation.

## Timing
- Start sampled high at edge T in IDLE: busy = 1 from T+1.
- With k iterations run, done is high for exactly the one cycle beginning at T + N + k·(N(N+1)+1) + 1. busy falls at the same edge.
- start while busy: ignored. start together with j_we in IDLE: the write lands and the run starts; the new J is used.
- j_we while busy: discarded, J unchanged.
- rst mid-run: immediate return to reset values. No done pulse. J contents are cleared.
- spin and iter_out hold until the next FIN.

## Test plan
- Reset mid-ACC of iteration 3 → next cycle busy=0, done=0, spin=0, iter_out=0; J reads back as 0 (verified by a subsequent run with all-zero behaviour).
- N=4, max_iter=1, noise_sh0=16, STABLE=15 → done pulse exactly 26 cycles after the start edge; iter_out=1.
- N=2, J01=J10=+16, ks=8, dt_shift=6, noise_sh0=4, max_iter=300 → spin ∈ {2'b00, 2'b11}.
- N=2, J01=J10=−16, same settings → spin ∈ {2'b01, 2'b10}.
- N=4 antiferromagnetic ring, J=−16 between neighbours, ks=8, noise_sh0=6, ANNEAL=8 → spin ∈ {4'b0101, 4'b1010}; early exit gives iter_out < max_iter=1000.
- j_we during busy with j_wdata=+100, and start pulsed during busy → stored J unchanged (golden-model result identical); exactly one done pulse.

Source files
------------

// File: rtl/ising_osc_solver_if.sv
// Host-side bundle for the oscillator Ising solver:
// coupling writes, run control, configuration and results.
interface ising_osc_solver_if #(
  parameter int N   = 16,
  parameter int JW  = 8,
  parameter int ITW = 16
) ();
  localparam int IW = $clog2(N);

  logic                 start;
  logic                 j_we;
  logic [IW-1:0]        j_row;
  logic [IW-1:0]        j_col;
  logic signed [JW-1:0] j_wdata;
  logic [7:0]           ks;
  logic [3:0]           dt_shift;
  logic [4:0]           noise_sh0;
  logic [ITW-1:0]       max_iter;
  logic                 busy;
  logic                 done;
  logic [N-1:0]         spin;
  logic [ITW-1:0]       iter_out;

  modport master (
    output start, j_we, j_row, j_col, j_wdata,
    output ks, dt_shift, noise_sh0, max_iter,
    input  busy, done, spin, iter_out
  );

  modport slave (
    input  start, j_we, j_row, j_col, j_wdata,
    input  ks, dt_shift, noise_sh0, max_iter,
    output busy, done, spin, iter_out
  );
endinterface

// File: rtl/ising_osc_solver.sv
// N-spin Kuramoto oscillator Ising solver with SHIL
// binarisation, annealed LFSR noise and early exit.
module ising_osc_solver #(
  parameter int N      = 16,
  parameter int PW     = 16,
  parameter int JW     = 8,
  parameter int ACCW   = 32,
  parameter int ITW    = 16,
  parameter int ANNEAL = 8,
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  ising_osc_solver_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(ANNEAL + 1);
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [PW:0] QV = (PW+1)'(1 << (PW - 2));
  localparam logic signed [PW:0] HV = (PW+1)'(1 << (PW - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ACC, S_UPD, S_ITER, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [PW-1:0] phi_q [N];
  logic [PW-1:0] phi_d [N];
  logic signed [JW-1:0] jm_q [N][N];
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [ITW-1:0] it_q, it_d, cap;
  logic [AW-1:0] an_q, an_d;
  logic [4:0] ns_q, ns_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] spin_q, spin_d, sv;
  logic [ITW-1:0] io_q, io_d;
  logic done_q, done_d;

  logic signed [PW-1:0] tj, t2;
  logic [PW-1:0] d2;
  logic signed [JW+PW-1:0] pj;
  logic signed [PW+8:0] pk;
  logic signed [15:0] nz;
  logic signed [ACCW-1:0] nzx, f, stp;

  function automatic logic signed [PW-1:0] tri_f(
    input logic [PW-1:0] x
  );
    logic signed [PW:0] s, r;
    s = $signed({x[PW-1], x});
    if (s > QV) r = HV - s;
    else if (s < -QV) r = -HV - s;
    else r = s;
    return r[PW-1:0];
  endfunction

  assign lfsr_nx = {lfsr_q[14:0],
    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cap = (bus.max_iter == '0) ? ITW'(1)
                                    : bus.max_iter;

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.spin     = spin_q;
  assign bus.iter_out = io_q;

  // spin i is -1 while its phase sits in [Q, 3Q)
  always_comb begin
    for (int k = 0; k < N; k++)
      sv[k] = phi_q[k][PW-1] ^ phi_q[k][PW-2];
  end

  // coupling term, SHIL term, noise and phase step
  always_comb begin
    tj = tri_f(phi_q[j_q] - phi_q[i_q]);
    pj = jm_q[i_q][j_q] * tj;
    if (j_q == i_q) pj = '0;
    d2 = {phi_q[i_q][PW-2:0], 1'b0};
    t2 = tri_f(d2);
    pk = $signed({1'b0, bus.ks}) * t2;
    nz = $signed(lfsr_q) >>> ns_q;
    nzx = ACCW'(nz);
    if (ns_q >= 5'd16) nzx = '0;
    f = acc_q - ACCW'(pk) + nzx;
    stp = f >>> bus.dt_shift;
  end

  // sequencer: next state and datapath next values
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    phi_d   = phi_q;
    lfsr_d  = lfsr_q;
    acc_d   = acc_q;
    it_d    = it_q;
    an_d    = an_q;
    ns_d    = ns_q;
    sc_d    = sc_q;
    prev_d  = prev_q;
    spin_d  = spin_q;
    io_d    = io_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          lfsr_d  = SEED;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          it_d    = '0;
          an_d    = '0;
          sc_d    = '0;
          prev_d  = '0;
          ns_d    = (bus.noise_sh0 > 5'd16) ? 5'd16
                                            : bus.noise_sh0;
        end
      end
      S_INIT: begin
        phi_d[i_q] = lfsr_q[15 -: PW];
        lfsr_d = lfsr_nx;
        if (i_q == LAST) begin
          i_d = '0;
          state_d = S_ACC;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_ACC: begin
        acc_d = acc_q + ACCW'(pj);
        if (j_q == LAST) begin
          j_d = '0;
          state_d = S_UPD;
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      S_UPD: begin
        phi_d[i_q] = phi_q[i_q] + stp[PW-1:0];
        lfsr_d = lfsr_nx;
        acc_d = '0;
        if (i_q == LAST) begin
          i_d = '0;
          state_d = S_ITER;
        end else begin
          i_d = i_q + IW'(1);
          state_d = S_ACC;
        end
      end
      S_ITER: begin
        it_d = it_q + ITW'(1);
        if (an_q == AW'(ANNEAL - 1)) begin
          an_d = '0;
          if (ns_q < 5'd16) ns_d = ns_q + 5'd1;
        end else begin
          an_d = an_q + AW'(1);
        end
        if (ns_q >= 5'd16)
          sc_d = (sv == prev_q) ? sc_q + SW'(1) : '0;
        else
          sc_d = '0;
        prev_d = sv;
        if (it_d == cap || sc_d == SW'(STABLE))
          state_d = S_FIN;
        else
          state_d = S_ACC;
      end
      S_FIN: begin
        spin_d  = sv;
        io_d    = it_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      for (int k = 0; k < N; k++) phi_q[k] <= '0;
      lfsr_q <= SEED;
      acc_q  <= '0;
      it_q   <= '0;
      an_q   <= '0;
      ns_q   <= '0;
      sc_q   <= '0;
      prev_q <= '0;
      spin_q <= '0;
      io_q   <= '0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      phi_q  <= phi_d;
      lfsr_q <= lfsr_d;
      acc_q  <= acc_d;
      it_q   <= it_d;
      an_q   <= an_d;
      ns_q   <= ns_d;
      sc_q   <= sc_d;
      prev_q <= prev_d;
      spin_q <= spin_d;
      io_q   <= io_d;
      done_q <= done_d;
    end
  end

  // coupling store: host writes land only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          jm_q[r][c] <= '0;
    end else if (bus.j_we && state_q == S_IDLE) begin
      jm_q[bus.j_row][bus.j_col] <= bus.j_wdata;
    end
  end
endmodule

// File: tb/tb_ising_osc_solver.sv
// Scoreboard bench for ising_osc_solver (N=4):
// directed runs, reference model, monitor on done.
module tb_ising_osc_solver;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ising_osc_solver_if #(.N(N), .JW(8), .ITW(16)) bus ();

  ising_osc_solver #(
    .N(N), .PW(16), .JW(8), .ACCW(32), .ITW(16),
    .ANNEAL(8), .STABLE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] spin;
    int iter;
    int lat;
    int kind;
    int t0;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  logic signed [7:0] jref [4][4];

  task automatic chk(input string nm, input int a,
                     input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: actual %0d required %0d",
                  nm, a, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int trim(input int x);
    logic [15:0] b;
    int s;
    b = x[15:0];
    s = int'($signed(b));
    if (s > 16384) return 32768 - s;
    if (s < -16384) return -32768 - s;
    return s;
  endfunction

  function automatic void model(
    input int ks, input int dt, input int nsh0,
    input int mi, output logic [3:0] sp_o,
    output int it_o, output int lat_o);
    int phi[4];
    logic [15:0] lf;
    logic [3:0] sp, prev;
    int nsh, nsv, sc, it, acc, f, cap;
    lf = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      phi[i] = int'(lf);
      lf = adv(lf);
    end
    nsh = (nsh0 > 16) ? 16 : nsh0;
    cap = (mi == 0) ? 1 : mi;
    sc = 0;
    it = 0;
    prev = '0;
    sp = '0;
    while (1) begin
      for (int i = 0; i < 4; i++) begin
        acc = 0;
        for (int j = 0; j < 4; j++)
          if (j != i)
            acc += int'(jref[i][j]) * trim(phi[j] - phi[i]);
        f = acc - ks * trim(2 * phi[i]);
        if (nsh < 16) f += int'($signed(lf)) >>> nsh;
        phi[i] = (phi[i] + (f >>> dt)) & 32'hFFFF;
        lf = adv(lf);
      end
      for (int i = 0; i < 4; i++)
        sp[i] = (phi[i] >= 16384 && phi[i] < 49152);
      it++;
      nsv = nsh;
      if (it % 8 == 0 && nsh < 16) nsh++;
      if (nsv >= 16) sc = (sp == prev) ? sc + 1 : 0;
      else sc = 0;
      prev = sp;
      if (it == cap || sc == 4) break;
    end
    sp_o = sp;
    it_o = it;
    lat_o = N + it * (N * (N + 1) + 1) + 1;
  endfunction

  task automatic setj(input int r, input int c,
                      input int v);
    bus.j_row = r[1:0];
    bus.j_col = c[1:0];
    bus.j_wdata = v[7:0];
    bus.j_we = 1'b1;
    tick;
    bus.j_we = 1'b0;
    jref[r][c] = v[7:0];
  endtask

  task automatic run(input int ks, input int dt,
    input int nsh, input int mi, input int kind,
    input bit hand, input logic [3:0] hs,
    input int hi, input int hl,
    input bit wr, input int wr_r, input int wr_c,
    input int wr_v);
    exp_t e;
    if (wr) begin
      bus.j_row = wr_r[1:0];
      bus.j_col = wr_c[1:0];
      bus.j_wdata = wr_v[7:0];
      bus.j_we = 1'b1;
      jref[wr_r][wr_c] = wr_v[7:0];
    end
    if (hand) begin
      e.spin = hs;
      e.iter = hi;
      e.lat = hl;
    end else begin
      model(ks, dt, nsh, mi, e.spin, e.iter, e.lat);
    end
    bus.ks = ks[7:0];
    bus.dt_shift = dt[3:0];
    bus.noise_sh0 = nsh[4:0];
    bus.max_iter = mi[15:0];
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.j_we = 1'b0;
    e.t0 = cyc;
    e.kind = kind;
    chk("busy_rise", int'(bus.busy), 1);
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 25000) begin
      tick;
      n++;
    end
    chk(nm, int'(bus.busy), 0);
    tick;
    tick;
  endtask

  initial begin : monitor
    exp_t e;
    bit pd;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pd = 1'b0;
        continue;
      end
      if (pd) chk("done_width", int'(bus.done), 0);
      pd = bus.done;
      if (bus.done) begin
        n_done++;
        chk("sb_pending", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("spin", int'(bus.spin), int'(e.spin));
          chk("iter_out", int'(bus.iter_out), e.iter);
          chk("latency", cyc - e.t0, e.lat);
          if (e.kind == 1)
            chk("ferro_pair",
                int'(bus.spin[0] == bus.spin[1]), 1);
          if (e.kind == 2)
            chk("afm_pair",
                int'(bus.spin[0] != bus.spin[1]), 1);
          if (e.kind == 3) begin
            chk("afm_ring", int'(bus.spin == 4'b0101 ||
                                 bus.spin == 4'b1010), 1);
            chk("early_exit",
                int'(bus.iter_out < 16'd1000), 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin : driver
    int nd;
    exp_t dummy;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        jref[r][c] = '0;
    bus.start = 1'b0;
    bus.j_we = 1'b0;
    bus.j_row = '0;
    bus.j_col = '0;
    bus.j_wdata = '0;
    bus.ks = '0;
    bus.dt_shift = '0;
    bus.noise_sh0 = 5'd16;
    bus.max_iter = '0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_spin", int'(bus.spin), 0);
    chk("rst_iter", int'(bus.iter_out), 0);

    run(0, 0, 16, 1, 0, 1, 4'b1111, 1, 26, 0, 0, 0, 0);
    wait_idle("idle_t1");
    run(0, 0, 16, 0, 0, 1, 4'b1111, 1, 26, 0, 0, 0, 0);
    wait_idle("idle_t2");
    run(0, 0, 16, 100, 0, 1, 4'b1111, 5, 110, 0, 0, 0, 0);
    wait_idle("idle_t3");

    setj(0, 1, 16);
    run(8, 6, 4, 300, 1, 0, 4'b0, 0, 0, 1, 1, 0, 16);
    wait_idle("idle_ferro");

    setj(0, 1, -16);
    setj(1, 0, -16);
    run(8, 6, 4, 300, 2, 0, 4'b0, 0, 0, 0, 0, 0, 0);
    wait_idle("idle_afm");

    setj(1, 2, -16);
    setj(2, 1, -16);
    setj(2, 3, -16);
    setj(3, 2, -16);
    setj(3, 0, -16);
    setj(0, 3, -16);
    run(8, 6, 6, 1000, 3, 0, 4'b0, 0, 0, 0, 0, 0, 0);
    wait_idle("idle_ring");

    nd = n_done;
    run(8, 6, 6, 1000, 3, 0, 4'b0, 0, 0, 0, 0, 0, 0);
    repeat (30) tick;
    bus.j_row = 2'd0;
    bus.j_col = 2'd1;
    bus.j_wdata = 8'sd100;
    bus.j_we = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.j_we = 1'b0;
    bus.start = 1'b0;
    wait_idle("idle_busy_wr");
    repeat (5) tick;
    chk("no_restart", int'(bus.busy), 0);
    chk("one_done", n_done - nd, 1);

    run(8, 6, 6, 1000, 3, 0, 4'b0, 0, 0, 0, 0, 0, 0);
    while (cyc < sbq[sbq.size() - 1].t0 + 4 + 2 * 21 + 2)
      tick;
    rst = 1'b1;
    dummy = sbq.pop_back();
    @(negedge clk);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_spin", int'(bus.spin), 0);
    chk("mid_rst_iter", int'(bus.iter_out), 0);
    tick;
    rst = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        jref[r][c] = '0;
    tick;
    run(0, 0, 16, 1, 0, 1, 4'b1111, 1, 26, 0, 0, 0, 0);
    wait_idle("idle_post_rst");

    repeat (4) tick;
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
